// File: rtl/hilo_unit.sv
// HI/LO multiply/divide responder for the EX stage.
// Models fixed MULT/DIV latency with a countdown and commits results to HI/LO at the end.
module hilo_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic {IDLE, RUN} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   a_q, a_d, b_q, b_d;
    logic [1:0]    op_q, op_d;
    logic [31:0]   hi_d, lo_d;

    logic [63:0]   prod_s, prod_u;
    logic [31:0]   res_hi, res_lo;
    logic          res_wr;

    assign busy      = (cnt_q != '0);
    assign stall_req = busy | (start & ~op[2]);

    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Result is formed only from the latched operands; a zero divisor suppresses the write.
    always_comb begin
        res_wr = 1'b1;
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
        case (op_q)
            2'd0: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            2'd1: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            2'd2: begin
                if (b_q == '0) begin
                    res_wr = 1'b0;
                end else if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
                    res_lo = 32'h8000_0000;
                    res_hi = 32'd0;
                end else begin
                    res_lo = $signed(a_q) / $signed(b_q);
                    res_hi = $signed(a_q) % $signed(b_q);
                end
            end
            default: begin
                if (b_q == '0) begin
                    res_wr = 1'b0;
                end else begin
                    res_lo = a_q / b_q;
                    res_hi = a_q % b_q;
                end
            end
        endcase
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi;
        lo_d    = lo;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            a_d     = rs;
                            b_d     = rt;
                            op_d    = op[1:0];
                            cnt_d   = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                            state_d = RUN;
                        end
                        OP_MTHI: hi_d = rs;
                        OP_MTLO: lo_d = rs;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    if (res_wr) begin
                        hi_d = res_hi;
                        lo_d = res_lo;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi      <= hi_d;
            lo      <= lo_d;
        end
    end
endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: directed vector table, hand-written corner sequences,
// and randomized ops checked against an arithmetic reference model.
module tb_hilo_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs, rt;
    logic        busy, stall_req;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi, m_lo;

    hilo_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
        .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] rs, rt, pre_hi, pre_lo, exp_hi, exp_lo;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Enter and leave at a negedge; start is high for exactly one rising edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        rs    = a;
        rt    = b;
        #1;
        check("stall_req_issue", 64'(stall_req), 64'(o <= 3'd3));
        @(negedge clk);
        start = 1'b0;
        op    = 3'($urandom);
        rs    = $urandom;
        rt    = $urandom;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        logic [63:0] pre;
        bit          stable;
        pre    = {hi, lo};
        stable = 1'b1;
        issue(o, a, b);
        cyc = 0;
        while (busy === 1'b1 && cyc < 50) begin
            cyc++;
            if ({hi, lo} !== pre) stable = 1'b0;
            @(negedge clk);
        end
        check("hold_during_busy", 64'(stable), 64'd1);
    endtask

    task automatic mt(input logic [31:0] h, input logic [31:0] l);
        int c;
        run_op(3'd4, h, 32'd0, c);
        run_op(3'd5, l, 32'd0, c);
    endtask

    task automatic model_apply(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd1: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd2: if (b != 0) begin
                p = sa / sb; m_lo = p[31:0];
                p = sa % sb; m_hi = p[31:0];
            end
            3'd3: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endtask

    initial begin
        int          c;
        logic [2:0]  o;
        logic [31:0] a, b;
        logic [63:0] pre;
        bit          stable;

        vecs[0] = '{"mult_neg",     3'd0, 32'hFFFFFFFE, 32'd3,        32'h1, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFA, MC};
        vecs[1] = '{"multu",        3'd1, 32'hFFFFFFFE, 32'd3,        32'h1, 32'h2, 32'h00000002, 32'hFFFFFFFA, MC};
        vecs[2] = '{"div_neg",      3'd2, 32'hFFFFFFF9, 32'd2,        32'h1, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, DC};
        vecs[3] = '{"divu",         3'd3, 32'd7,        32'd2,        32'h1, 32'h2, 32'h00000001, 32'h00000003, DC};
        vecs[4] = '{"div_by_zero",  3'd2, 32'd55,       32'd0,        32'hAAAA0000, 32'h0000BBBB, 32'hAAAA0000, 32'h0000BBBB, DC};
        vecs[5] = '{"div_overflow", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h1, 32'h2, 32'h00000000, 32'h80000000, DC};
        vecs[6] = '{"divu_by_zero", 3'd3, 32'd9,        32'd0,        32'h1, 32'h2, 32'h00000001, 32'h00000002, DC};
        vecs[7] = '{"mult_minsq",   3'd0, 32'h80000000, 32'h80000000, 32'h1, 32'h2, 32'h40000000, 32'h00000000, MC};
        vecs[8] = '{"div_negdiv",   3'd2, 32'd7,        32'hFFFFFFFE, 32'h1, 32'h2, 32'h00000001, 32'hFFFFFFFD, DC};
        vecs[9] = '{"divu_big",     3'd3, 32'hFFFFFFFF, 32'd10,       32'h1, 32'h2, 32'h00000005, 32'h19999999, DC};

        reset = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        rs    = '0;
        rt    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        reset = 1'b1;

        run_op(3'd4, 32'h12345678, 32'd0, c);
        check("mthi_cycles", 64'(c), 64'd0);
        check("mthi_hi", 64'(hi), 64'h12345678);

        for (int i = 0; i < 10; i++) begin
            mt(vecs[i].pre_hi, vecs[i].pre_lo);
            run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, c);
            check({vecs[i].name, "_cycles"}, 64'(c), 64'(vecs[i].exp_cyc));
            check({vecs[i].name, "_hi"}, 64'(hi), 64'(vecs[i].exp_hi));
            check({vecs[i].name, "_lo"}, 64'(lo), 64'(vecs[i].exp_lo));
        end

        // start while busy: DIVU and MTHI attempts must be ignored
        mt(32'd0, 32'd0);
        pre    = {hi, lo};
        stable = 1'b1;
        issue(3'd0, 32'hFFFFFFFE, 32'd3);
        c = 0;
        while (busy === 1'b1 && c < 50) begin
            c++;
            if ({hi, lo} !== pre) stable = 1'b0;
            if (c == 1) begin
                #1;
                check("stall_req_busy", 64'(stall_req), 64'd1);
            end
            if (c == 2) begin
                start = 1'b1; op = 3'd3; rs = 32'd100; rt = 32'd7;
            end else if (c == 3) begin
                start = 1'b1; op = 3'd4; rs = 32'hDEADBEEF; rt = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("ignore_hold", 64'(stable), 64'd1);
        check("ignore_cycles", 64'(c), 64'(MC));
        check("ignore_hi", 64'(hi), 64'hFFFFFFFF);
        check("ignore_lo", 64'(lo), 64'hFFFFFFFA);
        @(negedge clk);
        check("ignore_no_queue", 64'(busy), 64'd0);

        // reset in the middle of a DIV
        mt(32'hAAAA0000, 32'h0000BBBB);
        issue(3'd2, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        check("midreset_busy_before", 64'(busy), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_hilo", {hi, lo}, 64'd0);
        repeat (12) @(negedge clk);
        check("midreset_no_commit", {hi, lo}, 64'd0);
        check("midreset_idle", 64'(busy), 64'd0);

        // randomized ops against the reference model
        a = $urandom;
        b = $urandom;
        mt(a, b);
        m_hi = a;
        m_lo = b;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 5) == 0) b = 32'd0;
            if ($urandom_range(0, 9) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
            run_op(o, a, b, c);
            check("rand_cycles", 64'(c), (o <= 3'd1) ? 64'(MC) : (o <= 3'd3) ? 64'(DC) : 64'd0);
            model_apply(o, a, b);
            check("rand_hilo", {hi, lo}, {m_hi, m_lo});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
